// File: rtl/wire_monitor.sv
// wire_monitor
//   Load-side observer for a single asynchronously driven net. The line is
//   brought into the clk domain by a two-flop synchronizer, optionally
//   debounced, and presented as a settled level, one-cycle rise/fall pulses
//   and a saturating count of level changes.
//
// Build option:
//   WIRE_MONITOR_DEBOUNCE_EN  defined   -> debounce filter (dcnt) compiled in;
//                                          level accepts s2 only after
//                                          STABLE_CYCLES consecutive cycles
//                                          of disagreement with level.
//                             undefined -> level follows s2 every cycle;
//                                          STABLE_CYCLES is only range-checked.
//
// Parameters:
//   INIT_LEVEL     reset value of the synchronizer flops and level
//   STABLE_CYCLES  persistence required by the debounce filter (>= 1)
//   CNT_W          width of toggle_cnt
//
// Ports:
//   clk         clock, all state on the rising edge
//   rst         synchronous active-high reset
//   din         monitored net, asynchronous to clk
//   cnt_clr     synchronous clear of toggle_cnt (wins over an increment)
//   level       settled, registered view of din
//   rise        one-cycle pulse coincident with level going 0->1
//   fall        one-cycle pulse coincident with level going 1->0
//   toggle_cnt  level changes since reset/clear, saturating at all-ones

module wire_monitor #(
    parameter logic INIT_LEVEL    = 1'b0,
    parameter int   STABLE_CYCLES = 4,
    parameter int   CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             cnt_clr,
    output logic             level,
    output logic             rise,
    output logic             fall,
    output logic [CNT_W-1:0] toggle_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Elaboration-time guard on the debounce length.
    if (STABLE_CYCLES < 1) begin : g_param_check
        $error("wire_monitor: STABLE_CYCLES must be >= 1");
    end

    logic s1;
    logic s2;
    logic level_nxt;

`ifdef WIRE_MONITOR_DEBOUNCE_EN
    localparam int DCNT_W = $clog2(STABLE_CYCLES) + 1;
    localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(STABLE_CYCLES - 1);

    logic [DCNT_W-1:0] dcnt;
    logic [DCNT_W-1:0] dcnt_nxt;

    // Any cycle where s2 agrees with level restarts the count, so a reversal
    // during the qualification window discards the progress made so far.
    always_comb begin
        level_nxt = level;
        dcnt_nxt  = dcnt;
        if (s2 == level) begin
            dcnt_nxt = '0;
        end else if (dcnt == DCNT_LAST) begin
            level_nxt = s2;
            dcnt_nxt  = '0;
        end else begin
            dcnt_nxt = dcnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dcnt <= '0;
        end else begin
            dcnt <= dcnt_nxt;
        end
    end
`else
    always_comb begin
        level_nxt = s2;
    end
`endif

    // Edge pulses and the counter are derived from the same level_nxt that
    // loads level, so they land in the same cycle as the new level value.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1         <= INIT_LEVEL;
            s2         <= INIT_LEVEL;
            level      <= INIT_LEVEL;
            rise       <= 1'b0;
            fall       <= 1'b0;
            toggle_cnt <= '0;
        end else begin
            s1    <= din;
            s2    <= s1;
            level <= level_nxt;
            rise  <= level_nxt & ~level;
            fall  <= ~level_nxt & level;
            if (cnt_clr) begin
                toggle_cnt <= '0;
            end else if ((level_nxt != level) && (toggle_cnt != CNT_MAX)) begin
                toggle_cnt <= toggle_cnt + 1'b1;
            end
        end
    end

endmodule
